// File: rtl/snax_csr_bridge_pkg.sv
// Shared types and constants for the Snitch CSR to HWPE periph bridge.
package snax_csr_bridge_pkg;

    // Bridge control states: accept, issue on periph, wait for read data, hand back to CSR.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RSP  = 2'd3
    } bridge_state_e;

    // Read data returned when the periph slave never answers.
    localparam logic [31:0] TIMEOUT_DATA   = 32'hDEAD_BEEF;
    // Every periph access is a full 32-bit word.
    localparam logic [3:0]  PERIPH_BE_FULL = 4'hF;

endpackage

// File: rtl/snax_csr_periph_bridge.sv
// Converts one Snitch CSR request at a time into an HWPE periph-bus master
// transaction: remaps the CSR address, rejects unmapped addresses, tags each
// periph request and abandons reads that get no answer within TIMEOUT cycles.
//
// Handshakes: a CSR request transfers on a clock edge where csr_req_valid_i and
// csr_req_ready_o are both high; a CSR response transfers on an edge where
// csr_rsp_valid_o and csr_rsp_ready_i are both high, and valid/data stay put
// until then; a periph request transfers on an edge where periph_req_o and
// periph_gnt_i are both high, with address/wen/data/id held stable until then.
module snax_csr_periph_bridge
    import snax_csr_bridge_pkg::*;
#(
    parameter int unsigned ID          = 10,
    parameter logic [11:0] CSR_BASE    = 12'h3C0,
    parameter int unsigned N_REGS      = 32,
    parameter logic [31:0] PERIPH_BASE = 32'h0000_0000,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [11:0]   csr_req_addr_i,
    input  logic [31:0]   csr_req_data_i,
    input  logic          csr_req_write_i,
    input  logic          csr_req_valid_i,
    output logic          csr_req_ready_o,
    output logic [31:0]   csr_rsp_data_o,
    output logic          csr_rsp_valid_o,
    input  logic          csr_rsp_ready_i,
    output logic          periph_req_o,
    input  logic          periph_gnt_i,
    output logic [31:0]   periph_add_o,
    output logic          periph_wen_o,
    output logic [3:0]    periph_be_o,
    output logic [31:0]   periph_data_o,
    output logic [ID-1:0] periph_id_o,
    input  logic [31:0]   periph_r_data_i,
    input  logic          periph_r_valid_i,
    input  logic [ID-1:0] periph_r_id_i,
    output logic          err_o,
    output bridge_state_e dbg_state_o
);

    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam logic [12:0] RANGE_LO = {1'b0, CSR_BASE};
    localparam logic [12:0] RANGE_HI = {1'b0, CSR_BASE} + 13'(N_REGS);

    bridge_state_e state_q, state_d;
    logic [31:0]   add_q, add_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          write_q, write_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [ID-1:0] tag_q, tag_d;
    logic [ID-1:0] rd_tag_q, rd_tag_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    logic          in_range;
    logic [31:0]   remapped_add;
    logic          rd_match;
    logic          tmo_last;

    // Address decode of the incoming CSR request; 13 bits so BASE+N_REGS cannot overflow.
    always_comb begin
        in_range     = ({1'b0, csr_req_addr_i} >= RANGE_LO) &&
                       ({1'b0, csr_req_addr_i} <  RANGE_HI);
        remapped_add = PERIPH_BASE + ((32'(csr_req_addr_i) - 32'(CSR_BASE)) << 2);
    end

    // Read completion and timeout conditions; the counter hits TIMEOUT on the
    // TIMEOUT-th WAIT cycle, so that cycle is the last one a reply can arrive in.
    always_comb begin
        rd_match = periph_r_valid_i && (periph_r_id_i == rd_tag_q);
        tmo_last = (tmo_q == TW'(TIMEOUT - 1));
    end

    // Next-state logic and datapath updates for the bridge FSM.
    always_comb begin
        state_d    = state_q;
        add_d      = add_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        rsp_data_d = rsp_data_q;
        tag_d      = tag_q;
        rd_tag_d   = rd_tag_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (csr_req_valid_i) begin
                    add_d   = remapped_add;
                    wdata_d = csr_req_data_i;
                    write_d = csr_req_write_i;
                    if (in_range) begin
                        state_d = REQ;
                    end else if (csr_req_write_i) begin
                        // Unmapped write: dropped silently apart from the error pulse.
                        err_d = 1'b1;
                    end else begin
                        // Unmapped read still owes the core a response.
                        rsp_data_d = '0;
                        err_d      = 1'b1;
                        state_d    = RSP;
                    end
                end
            end
            REQ: begin
                if (periph_gnt_i) begin
                    tag_d = tag_q + ID'(1);
                    if (write_q) begin
                        state_d = IDLE;
                    end else begin
                        rd_tag_d = tag_q;
                        tmo_d    = '0;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (rd_match) begin
                    rsp_data_d = periph_r_data_i;
                    state_d    = RSP;
                end else if (tmo_last) begin
                    rsp_data_d = TIMEOUT_DATA;
                    err_d      = 1'b1;
                    state_d    = RSP;
                end
            end
            RSP: begin
                if (csr_rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any outstanding transaction.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            add_q      <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            rsp_data_q <= '0;
            tag_q      <= '0;
            rd_tag_q   <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            add_q      <= add_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            rsp_data_q <= rsp_data_d;
            tag_q      <= tag_d;
            rd_tag_q   <= rd_tag_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    // Outputs come from registers or a state decode only; never from periph inputs.
    always_comb begin
        csr_req_ready_o = (state_q == IDLE) && !rst_i;
        csr_rsp_valid_o = (state_q == RSP);
        csr_rsp_data_o  = rsp_data_q;
        periph_req_o    = (state_q == REQ);
        periph_wen_o    = (state_q == REQ) && !write_q;
        periph_be_o     = (state_q == REQ) ? PERIPH_BE_FULL : 4'h0;
        periph_add_o    = add_q;
        periph_data_o   = wdata_q;
        periph_id_o     = tag_q;
        err_o           = err_q;
        dbg_state_o     = state_q;
    end

endmodule

// File: tb/tb_snax_csr_periph_bridge.sv
// Self-checking bench for snax_csr_periph_bridge: directed scenarios followed by
// randomized CSR traffic, with the bench acting as the periph slave and a
// transaction-level model predicting addresses, tags, responses and errors.
module tb_snax_csr_periph_bridge;
  import snax_csr_bridge_pkg::*;

  localparam int unsigned ID_W     = 10;
  localparam int unsigned TMO      = 64;
  localparam int unsigned TAG_MOD  = 1 << ID_W;
  localparam logic [31:0] P_BASE   = 32'h0000_0000;

  logic              clk;
  logic              rst;
  logic [11:0]       csr_req_addr;
  logic [31:0]       csr_req_data;
  logic              csr_req_write;
  logic              csr_req_valid;
  logic              csr_req_ready;
  logic [31:0]       csr_rsp_data;
  logic              csr_rsp_valid;
  logic              csr_rsp_ready;
  logic              periph_req;
  logic              periph_gnt;
  logic [31:0]       periph_add;
  logic              periph_wen;
  logic [3:0]        periph_be;
  logic [31:0]       periph_data;
  logic [ID_W-1:0]   periph_id;
  logic [31:0]       periph_r_data;
  logic              periph_r_valid;
  logic [ID_W-1:0]   periph_r_id;
  logic              err;
  bridge_state_e     dbg_state;

  int n_cmp;
  int n_err;
  int exp_tag;

  snax_csr_periph_bridge #(
    .ID          (ID_W),
    .CSR_BASE    (12'h3C0),
    .N_REGS      (32),
    .PERIPH_BASE (P_BASE),
    .TIMEOUT     (TMO)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .csr_req_addr_i   (csr_req_addr),
    .csr_req_data_i   (csr_req_data),
    .csr_req_write_i  (csr_req_write),
    .csr_req_valid_i  (csr_req_valid),
    .csr_req_ready_o  (csr_req_ready),
    .csr_rsp_data_o   (csr_rsp_data),
    .csr_rsp_valid_o  (csr_rsp_valid),
    .csr_rsp_ready_i  (csr_rsp_ready),
    .periph_req_o     (periph_req),
    .periph_gnt_i     (periph_gnt),
    .periph_add_o     (periph_add),
    .periph_wen_o     (periph_wen),
    .periph_be_o      (periph_be),
    .periph_data_o    (periph_data),
    .periph_id_o      (periph_id),
    .periph_r_data_i  (periph_r_data),
    .periph_r_valid_i (periph_r_valid),
    .periph_r_id_i    (periph_r_id),
    .err_o            (err),
    .dbg_state_o      (dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- model helpers ----------------
  function automatic bit model_in_range(input logic [11:0] a);
    return (int'(a) >= 'h3C0) && (int'(a) < 'h3C0 + 32);
  endfunction

  function automatic logic [31:0] model_add(input logic [11:0] a);
    return P_BASE + (32'(a) - 32'h3C0) * 32'd4;
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_ready"},     32'(csr_req_ready), 32'd0);
    chk({tag, "_req"},       32'(periph_req),    32'd0);
    chk({tag, "_wen"},       32'(periph_wen),    32'd0);
    chk({tag, "_be"},        32'(periph_be),     32'd0);
    chk({tag, "_add"},       periph_add,         32'd0);
    chk({tag, "_pdata"},     periph_data,        32'd0);
    chk({tag, "_id"},        32'(periph_id),     32'd0);
    chk({tag, "_rsp_valid"}, 32'(csr_rsp_valid), 32'd0);
    chk({tag, "_rsp_data"},  csr_rsp_data,       32'd0);
    chk({tag, "_err"},       32'(err),           32'd0);
  endtask

  // Current cycle is the first RSP cycle; hold ready low rrdy cycles then consume.
  task automatic rsp_phase(input string tag, input logic [31:0] exp_data, input bit exp_err,
                           input int rrdy);
    chk({tag, "_rsp_valid"}, 32'(csr_rsp_valid), 32'd1);
    chk({tag, "_rsp_data"},  csr_rsp_data,       exp_data);
    chk({tag, "_rsp_err"},   32'(err),           32'(exp_err));
    chk({tag, "_rsp_busy"},  32'(csr_req_ready), 32'd0);
    for (int i = 0; i < rrdy; i++) begin
      step();
      chk({tag, "_rsp_hold_valid"}, 32'(csr_rsp_valid), 32'd1);
      chk({tag, "_rsp_hold_data"},  csr_rsp_data,       exp_data);
      chk({tag, "_rsp_hold_err"},   32'(err),           32'd0);
    end
    csr_rsp_ready = 1'b1;
    step();
    csr_rsp_ready = 1'b0;
    chk({tag, "_rsp_done_valid"}, 32'(csr_rsp_valid), 32'd0);
    chk({tag, "_rsp_done_ready"}, 32'(csr_req_ready), 32'd1);
    chk({tag, "_rsp_done_err"},   32'(err),           32'd0);
  endtask

  // Presents a CSR request for one accept edge; caller is in an IDLE cycle.
  task automatic issue(input logic [11:0] addr, input logic [31:0] data, input bit wr);
    chk("pre_issue_ready", 32'(csr_req_ready), 32'd1);
    csr_req_addr  = addr;
    csr_req_data  = data;
    csr_req_write = wr;
    csr_req_valid = 1'b1;
    step();
    csr_req_valid = 1'b0;
    csr_req_addr  = 12'($urandom);
    csr_req_data  = $urandom;
  endtask

  // Current cycle is the first REQ cycle; stall gdly cycles then grant.
  task automatic grant_phase(input string tag, input logic [11:0] addr, input logic [31:0] data,
                             input bit wr, input int gdly);
    for (int i = 0; i <= gdly; i++) begin
      chk({tag, "_req"}, 32'(periph_req), 32'd1);
      chk({tag, "_add"}, periph_add,      model_add(addr));
      chk({tag, "_wen"}, 32'(periph_wen), 32'(!wr));
      chk({tag, "_be"},  32'(periph_be),  32'hF);
      chk({tag, "_id"},  32'(periph_id),  32'(exp_tag));
      if (wr) chk({tag, "_pdata"}, periph_data, data);
      if (i < gdly) begin
        // Stray read data while still requesting must be ignored.
        periph_r_valid = 1'($urandom_range(0, 1));
        periph_r_id    = ID_W'(exp_tag);
        periph_r_data  = $urandom;
        step();
        periph_r_valid = 1'b0;
      end
    end
    periph_gnt = 1'b1;
    step();
    periph_gnt = 1'b0;
    exp_tag = (exp_tag + 1) % TAG_MOD;
  endtask

  task automatic do_write(input logic [11:0] addr, input logic [31:0] data, input int gdly,
                          input bit ack);
    logic [ID_W-1:0] wtag;
    issue(addr, data, 1'b1);
    if (!model_in_range(addr)) begin
      chk("oor_wr_err",   32'(err),           32'd1);
      chk("oor_wr_req",   32'(periph_req),    32'd0);
      chk("oor_wr_rsp",   32'(csr_rsp_valid), 32'd0);
      chk("oor_wr_ready", 32'(csr_req_ready), 32'd1);
      step();
      chk("oor_wr_err_end", 32'(err),        32'd0);
      chk("oor_wr_req2",    32'(periph_req), 32'd0);
      return;
    end
    wtag = ID_W'(exp_tag);
    grant_phase("wr", addr, data, 1'b1, gdly);
    chk("wr_done_ready", 32'(csr_req_ready), 32'd1);
    chk("wr_done_req",   32'(periph_req),    32'd0);
    chk("wr_no_rsp",     32'(csr_rsp_valid), 32'd0);
    if (ack) begin
      // Write acknowledge arriving in IDLE is absorbed.
      periph_r_valid = 1'b1;
      periph_r_id    = wtag;
      periph_r_data  = $urandom;
      step();
      periph_r_valid = 1'b0;
      chk("wr_ack_no_rsp", 32'(csr_rsp_valid), 32'd0);
      chk("wr_ack_ready",  32'(csr_req_ready), 32'd1);
    end
  endtask

  // mode 0: reply after rdly cycles; 1: never reply; 2: reply in the expiry cycle.
  task automatic do_read(input logic [11:0] addr, input int gdly, input int rdly, input bit decoy,
                         input int mode, input logic [31:0] rdata, input int rrdy);
    logic [ID_W-1:0] rtag;
    issue(addr, $urandom, 1'b0);
    if (!model_in_range(addr)) begin
      chk("oor_rd_req", 32'(periph_req), 32'd0);
      rsp_phase("oor_rd", 32'd0, 1'b1, rrdy);
      return;
    end
    rtag = ID_W'(exp_tag);
    grant_phase("rd", addr, 32'd0, 1'b0, gdly);
    chk("rd_wait_req", 32'(periph_req),    32'd0);
    chk("rd_wait_rsp", 32'(csr_rsp_valid), 32'd0);
    if (mode == 0) begin
      for (int i = 0; i < rdly; i++) begin
        periph_r_valid = decoy;
        periph_r_id    = rtag ^ ID_W'($urandom_range(1, TAG_MOD - 1));
        periph_r_data  = $urandom;
        step();
        periph_r_valid = 1'b0;
        chk("rd_wait_hold", 32'(csr_rsp_valid), 32'd0);
      end
      periph_r_valid = 1'b1;
      periph_r_id    = rtag;
      periph_r_data  = rdata;
      step();
      periph_r_valid = 1'b0;
      periph_r_data  = $urandom;
      rsp_phase("rd", rdata, 1'b0, rrdy);
    end else begin
      // Walk to the TMO-th WAIT cycle with no matching reply.
      for (int i = 1; i < int'(TMO); i++) begin
        periph_r_valid = decoy;
        periph_r_id    = rtag ^ ID_W'($urandom_range(1, TAG_MOD - 1));
        step();
        periph_r_valid = 1'b0;
        chk("tmo_wait_hold", 32'(csr_rsp_valid), 32'd0);
        chk("tmo_wait_err",  32'(err),           32'd0);
      end
      if (mode == 2) begin
        periph_r_valid = 1'b1;
        periph_r_id    = rtag;
        periph_r_data  = rdata;
        step();
        periph_r_valid = 1'b0;
        rsp_phase("tmo_edge", rdata, 1'b0, rrdy);
      end else begin
        step();
        rsp_phase("tmo", 32'hDEAD_BEEF, 1'b1, rrdy);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [ID_W-1:0] old_tag;
    int              kind;
    logic [11:0]     addr;

    n_cmp          = 0;
    n_err          = 0;
    exp_tag        = 0;
    rst            = 1'b1;
    csr_req_addr   = '0;
    csr_req_data   = '0;
    csr_req_write  = 1'b0;
    csr_req_valid  = 1'b0;
    csr_rsp_ready  = 1'b0;
    periph_gnt     = 1'b0;
    periph_r_data  = '0;
    periph_r_valid = 1'b0;
    periph_r_id    = '0;

    // Reset state.
    step();
    step();
    chk_outputs_zero("reset");
    chk("reset_state", 32'(dbg_state), 32'(IDLE));
    rst = 1'b0;
    step();
    chk("post_reset_ready", 32'(csr_req_ready), 32'd1);

    // Directed: write, then read with slow grant and slow consumer.
    do_write(12'h3C2, 32'h1234_5678, 0, 1'b0);
    do_read(12'h3C5, 3, 0, 1'b0, 0, 32'hCAFE_0001, 4);

    // Timeout and reply-in-expiry-cycle.
    do_read(12'h3C7, 0, 0, 1'b0, 1, 32'h0, 0);
    do_read(12'h3DF, 1, 0, 1'b1, 2, 32'h5A5A_0F0F, 1);

    // Unmapped addresses at both range edges.
    do_read(12'h3E0, 0, 0, 1'b0, 0, 32'h0, 2);
    do_write(12'h3BF, 32'hFFFF_FFFF, 0, 1'b0);
    do_write(12'h3C0, 32'h0BAD_F00D, 2, 1'b1);
    do_write(12'h3DF, 32'h0000_0001, 0, 1'b0);

    // Mismatching ids before the real reply.
    do_read(12'h3D0, 0, 3, 1'b1, 0, 32'h7777_0007, 0);

    // Reset while a read is outstanding; a late reply must be ignored.
    issue(12'h3C4, 32'h0, 1'b0);
    old_tag = ID_W'(exp_tag);
    grant_phase("rst_rd", 12'h3C4, 32'h0, 1'b0, 0);
    step();
    rst = 1'b1;
    step();
    chk_outputs_zero("mid_reset");
    rst = 1'b0;
    exp_tag = 0;
    periph_r_valid = 1'b1;
    periph_r_id    = old_tag;
    periph_r_data  = 32'h1111_2222;
    step();
    periph_r_valid = 1'b0;
    chk("late_rvalid_rsp",   32'(csr_rsp_valid), 32'd0);
    chk("late_rvalid_ready", 32'(csr_req_ready), 32'd1);
    step();
    chk("late_rvalid_rsp2", 32'(csr_rsp_valid), 32'd0);
    do_read(12'h3C1, 0, 1, 1'b0, 0, 32'h3333_4444, 0);

    // Tag wrap: back-to-back writes through 1025 tags.
    for (int n = 0; n < int'(TAG_MOD) + 1; n++) begin
      do_write(12'(12'h3C0 + $urandom_range(0, 31)), $urandom, 0, 1'b0);
    end

    // Randomized mix.
    for (int n = 0; n < 150; n++) begin
      kind = int'($urandom_range(0, 99));
      addr = 12'($urandom_range(12'h3B0, 12'h3EF));
      if (kind < 40) begin
        do_write(addr, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end else if (kind < 94) begin
        do_read(addr, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)),
                1'($urandom_range(0, 1)), 0, $urandom, int'($urandom_range(0, 3)));
      end else begin
        do_read(addr, int'($urandom_range(0, 2)), 0, 1'($urandom_range(0, 1)),
                int'($urandom_range(1, 2)), $urandom, int'($urandom_range(0, 2)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
